// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream into instruction
// memory while holding the CPU in reset, then releases the core.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [7:0]            imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   bytes_loaded
);

  localparam int unsigned LEN_W = 34;

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [LEN_W-1:0]      CAPACITY = (LEN_W'(1) << ADDR_WIDTH) - LEN_W'(BASE_ADDR);

  logic [2:0]            state, state_n;
  logic [1:0]            len_cnt, len_cnt_n;
  logic [23:0]           len_word, len_word_n;
  logic [LEN_W-1:0]      len_total, len_total_n;
  logic [7:0]            checksum, checksum_n;
  logic [ADDR_WIDTH:0]   bytes_loaded_n;
  logic                  imem_we_n;
  logic [ADDR_WIDTH-1:0] imem_addr_n;
  logic [7:0]            imem_wdata_n;
  logic                  in_ready_n, cpu_reset_n, load_done_n, error_n;
  logic                  accept;
  logic [31:0]           word_cnt;
  logic [LEN_W-1:0]      byte_cnt;

  assign accept   = in_valid && in_ready;
  assign word_cnt = {in_data, len_word};
  assign byte_cnt = {word_cnt, 2'b00};

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    state_n        = state;
    len_cnt_n      = len_cnt;
    len_word_n     = len_word;
    len_total_n    = len_total;
    checksum_n     = checksum;
    bytes_loaded_n = bytes_loaded;
    imem_we_n      = 1'b0;
    imem_addr_n    = imem_addr;
    imem_wdata_n   = imem_wdata;

    case (state)
      ST_LEN: begin
        if (accept) begin
          len_cnt_n  = len_cnt + 2'd1;
          len_word_n = {in_data, len_word[23:8]};
          if (len_cnt == 2'd3) begin
            len_total_n = byte_cnt;
            if (byte_cnt > CAPACITY) begin
              state_n = ST_ERROR;
            end else if (word_cnt == 32'd0) begin
              state_n = ST_CHECK;
            end else begin
              state_n = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          imem_we_n      = 1'b1;
          imem_wdata_n   = in_data;
          imem_addr_n    = BASE + bytes_loaded[ADDR_WIDTH-1:0];
          bytes_loaded_n = bytes_loaded + (ADDR_WIDTH+1)'(1);
          checksum_n     = checksum + in_data;
          if (LEN_W'(bytes_loaded) + LEN_W'(1) == len_total) begin
            state_n = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          state_n = (in_data == checksum) ? ST_RUN : ST_ERROR;
        end
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          state_n        = ST_LEN;
          len_cnt_n      = 2'd0;
          len_word_n     = 24'd0;
          checksum_n     = 8'd0;
          bytes_loaded_n = '0;
        end
      end
      default: state_n = ST_LEN;
    endcase

    in_ready_n  = (state_n == ST_LEN) || (state_n == ST_DATA) || (state_n == ST_CHECK);
    cpu_reset_n = (state_n != ST_RUN);
    load_done_n = (state_n == ST_RUN);
    error_n     = (state_n == ST_ERROR);
  end

  // State and output registers; reset wins over reload and accepted bytes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_LEN;
      len_cnt      <= 2'd0;
      len_word     <= 24'd0;
      len_total    <= '0;
      checksum     <= 8'd0;
      bytes_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE;
      imem_wdata   <= 8'd0;
      in_ready     <= 1'b1;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      len_cnt      <= len_cnt_n;
      len_word     <= len_word_n;
      len_total    <= len_total_n;
      checksum     <= checksum_n;
      bytes_loaded <= bytes_loaded_n;
      imem_we      <= imem_we_n;
      imem_addr    <= imem_addr_n;
      imem_wdata   <= imem_wdata_n;
      in_ready     <= in_ready_n;
      cpu_reset    <= cpu_reset_n;
      load_done    <= load_done_n;
      error        <= error_n;
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot controller that sequences loading of the CPU's byte-wide instruction memory from an external byte stream (UART/debug bridge) before releasing the core.
- Holds `risc_v_cpu` in reset and parses a length-prefixed, checksummed image.
- Writes the image payload byte-by-byte into instruction memory in file order, then deasserts the CPU reset.
- Sits between the host link and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 10, instruction memory byte-address width; capacity is 2^ADDR_WIDTH bytes.
- BASE_ADDR, 0, first byte address written.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle pulse; restarts loading from RUN or ERROR.
- imem_we  output  1  instruction memory byte write enable.
- imem_addr  output  ADDR_WIDTH  byte address.
- imem_wdata  output  8  byte to write.
- cpu_reset  output  1  active-high reset to the CPU; 1 except in RUN.
- load_done  output  1  1 while in RUN.
- error  output  1  1 while in ERROR.
- bytes_loaded  output  ADDR_WIDTH+1  payload bytes written since the last restart.

Behaviour:
- Acceptance: a byte is accepted on the cycle where in_valid && in_ready.
  - in_ready = 1 in LEN, DATA and CHECK; 0 in RUN and ERROR.
  - in_ready does not depend combinationally on in_valid.
- Reset (reset==0 at a clock edge), from any state including mid-DATA:
  - state=LEN, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_reset=1, load_done=0, error=0, bytes_loaded=0.
  - Byte, length and checksum counters cleared.
  - Memory contents are not cleared.
- LEN state:
  - Accepts 4 bytes forming word count N, little-endian (first byte = N[7:0]).
  - On the 4th byte, compute N*4 in 34 bits (no overflow).
    - N*4 > 2^ADDR_WIDTH - BASE_ADDR → ERROR.
    - N==0 → CHECK.
    - Otherwise → DATA.
- DATA state:
  - Each accepted byte is registered. On the next cycle:
    - imem_we=1, imem_wdata=byte.
    - imem_addr=BASE_ADDR+bytes_loaded (pre-increment value).
    - bytes_loaded increments.
  - Write latency is exactly 1 cycle.
  - imem_we=0 on cycles with no accepted byte.
  - Checksum accumulates as an 8-bit modulo-256 sum of payload bytes only; length bytes are excluded.
  - After the (4N)th byte is accepted → CHECK.
  - The last write occurs in the first CHECK cycle.
- CHECK state: accepts 1 byte.
  - Byte equals checksum → RUN.
  - Otherwise → ERROR.
- RUN state: cpu_reset=0 and load_done=1, starting the cycle after the check byte is accepted.
  - reload=1 → LEN next cycle: cpu_reset=1, bytes_loaded=0, checksum=0.
- ERROR state: error=1, cpu_reset=1, no memory writes.
  - reload=1 → LEN with the same clearing as from RUN.
- reload is ignored in LEN, DATA and CHECK.
- reset has priority over reload and over an accepted byte in the same cycle.
- State encoding is internal. Only the listed outputs are visible.

Test Plan:
- N=1 stream 01 00 00 00, 00 C5 87 B3, FF:
  - Writes mem[0]=00, mem[1]=C5, mem[2]=87, mem[3]=B3 on consecutive cycles.
  - Then cpu_reset=0, load_done=1, bytes_loaded=4, in_ready=0.
- Same stream with checksum 00:
  - Memory written as above.
  - Then error=1, cpu_reset stays 1, in_ready=0.
  - reload pulse → in_ready=1, bytes_loaded=0, error=0.
- ADDR_WIDTH=10, length bytes 01 01 00 00 (N=257, 1028 bytes):
  - ERROR the cycle after the 4th byte.
  - imem_we never asserted.
- Length 00 00 00 00 then checksum 00:
  - RUN with zero writes, bytes_loaded=0.
- N=2 with in_valid toggling 1,0,0,1 randomly:
  - Exactly 8 writes, addresses 0..7 contiguous.
  - Each write occurs 1 cycle after its accept.
  - Checksum is correct → RUN.
- Assert reset low after 2 payload bytes of an N=2 load:
  - Next cycle state LEN, bytes_loaded=0, cpu_reset=1, imem_we=0.
  - A fresh full image then loads correctly.
  - reload asserted with reset low is ignored.
